// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit serializer.
// Build option: USB_TX_CRC_INV_EN selects complemented CRC bits on the wire.
package usb_tx_pkg;

    localparam int USB_DATA_W = 8;
    localparam int USB_CRC_W  = 16;

    // CRC is appended starting from its most significant bit
    localparam bit CRC_MSB_FIRST = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        CRC_LOAD,
        CRC,
        DONE
    } tx_state_t;

endpackage

// File: rtl/usb_tx_byte_buf.sv
// One-entry byte holding register with valid/ready handshake and last flag.
// Ready is taken straight from the empty flag so the source never waits on logic.
module usb_tx_byte_buf
    import usb_tx_pkg::*;
#(
    parameter int DATA_W = USB_DATA_W
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic [DATA_W-1:0] byte_di,
    input  logic              byte_vld,
    input  logic              byte_last,
    output logic              byte_rdy,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic              full_o
);

    logic              full_q, full_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] data_q, data_d;

    assign byte_rdy = ~full_q;
    assign full_o   = full_q;
    assign data_o   = data_q;
    assign last_o   = last_q;

    always_comb begin
        full_d = full_q;
        last_d = last_q;
        data_d = data_q;
        if (pop_i) begin
            full_d = 1'b0;
        end
        if (byte_vld && !full_q) begin
            full_d = 1'b1;
            last_d = byte_last;
            data_d = byte_di;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            full_q <= 1'b0;
            last_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            last_q <= last_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/usb_crc16_tx_ser.sv
// USB transmit serializer: bytes out LSB-first, then the CRC snapshot MSB-first.
// Build option: USB_TX_CRC_INV_EN transmits the CRC bits complemented.
module usb_crc16_tx_ser
    import usb_tx_pkg::*;
#(
    parameter int DATA_W = USB_DATA_W,
    parameter int CRC_W  = USB_CRC_W
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              bit_en,
    input  logic [DATA_W-1:0] byte_di,
    input  logic              byte_vld,
    input  logic              byte_last,
    output logic              byte_rdy,
    input  logic [CRC_W-1:0]  crc16_i,
    output logic              crc16_di,
    output logic              crc16_en,
    output logic              ser_do,
    output logic              ser_vld,
    output logic              busy,
    output logic              pkt_done,
    output logic              underrun
);

    localparam int BW = $clog2(DATA_W);
    localparam int CW = $clog2(CRC_W);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [CW-1:0] CRC_LAST = CW'(CRC_W - 1);

`ifdef USB_TX_CRC_INV_EN
    localparam logic CRC_INV = 1'b1;
`else
    localparam logic CRC_INV = 1'b0;
`endif

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     bitcnt_q, bitcnt_d;
    logic              cur_last_q, cur_last_d;
    logic [CRC_W-1:0]  crcsh_q, crcsh_d;
    logic [CW-1:0]     crccnt_q, crccnt_d;
    logic              underrun_q, underrun_d;

    logic              pop;
    logic [DATA_W-1:0] hold_data;
    logic              hold_last;
    logic              hold_full;
    logic              crc_bit;

    usb_tx_byte_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk       (clk),
        .reset_l   (reset_l),
        .byte_di   (byte_di),
        .byte_vld  (byte_vld),
        .byte_last (byte_last),
        .byte_rdy  (byte_rdy),
        .pop_i     (pop),
        .data_o    (hold_data),
        .last_o    (hold_last),
        .full_o    (hold_full)
    );

    assign crc_bit  = CRC_MSB_FIRST ? crcsh_q[CRC_W-1] : crcsh_q[0];
    assign busy     = (state_q != IDLE);
    assign underrun = underrun_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        cur_last_d = cur_last_q;
        crcsh_d    = crcsh_q;
        crccnt_d   = crccnt_q;
        underrun_d = 1'b0;
        pop        = 1'b0;
        ser_do     = 1'b0;
        ser_vld    = 1'b0;
        crc16_di   = 1'b0;
        crc16_en   = 1'b0;
        pkt_done   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (hold_full) begin
                    shift_d    = hold_data;
                    cur_last_d = hold_last;
                    bitcnt_d   = '0;
                    pop        = 1'b1;
                    state_d    = DATA;
                end
            end
            DATA: begin
                crc16_di = shift_q[0];
                if (bit_en) begin
                    ser_do   = shift_q[0];
                    ser_vld  = 1'b1;
                    crc16_en = 1'b1;
                    shift_d  = shift_q >> 1;
                    bitcnt_d = bitcnt_q + BW'(1);
                    if (bitcnt_q == BIT_LAST) begin
                        if (cur_last_q) begin
                            state_d = CRC_LOAD;
                        end else if (hold_full) begin
                            // back-to-back reload keeps the bit stream gapless
                            shift_d    = hold_data;
                            cur_last_d = hold_last;
                            bitcnt_d   = '0;
                            pop        = 1'b1;
                        end else begin
                            underrun_d = 1'b1;
                            state_d    = IDLE;
                        end
                    end
                end
            end
            CRC_LOAD: begin
                // crc16_i already includes the final data bit here
                crcsh_d  = crc16_i;
                crccnt_d = '0;
                state_d  = CRC;
            end
            CRC: begin
                if (bit_en) begin
                    ser_do   = crc_bit ^ CRC_INV;
                    ser_vld  = 1'b1;
                    crccnt_d = crccnt_q + CW'(1);
                    if (CRC_MSB_FIRST) begin
                        crcsh_d = {crcsh_q[CRC_W-2:0], 1'b0};
                    end else begin
                        crcsh_d = {1'b0, crcsh_q[CRC_W-1:1]};
                    end
                    if (crccnt_q == CRC_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                pkt_done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            cur_last_q <= 1'b0;
            crcsh_q    <= '0;
            crccnt_q   <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            cur_last_q <= cur_last_d;
            crcsh_q    <= crcsh_d;
            crccnt_q   <= crccnt_d;
            underrun_q <= underrun_d;
        end
    end

endmodule
